// File: rtl/mmio_pkg.sv
// Shared types and register-map index helpers for the MMIO register window.
package mmio_pkg;

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  localparam logic [31:0] DefaultBaseAddr = 32'hFFFF_FF00;

  function automatic int unsigned sw_idx();
    return 0;
  endfunction

  function automatic int unsigned led_idx(int unsigned sw_ch);
    return sw_ch;
  endfunction

  function automatic int unsigned bt_idx(int unsigned sw_ch, int unsigned led_ch);
    return sw_ch + led_ch;
  endfunction

  function automatic int unsigned edge_idx(int unsigned sw_ch, int unsigned led_ch,
                                           int unsigned bt_ch);
    return sw_ch + led_ch + bt_ch;
  endfunction

  function automatic int unsigned sepc_idx(int unsigned sw_ch, int unsigned led_ch,
                                           int unsigned bt_ch);
    return sw_ch + led_ch + bt_ch + 1;
  endfunction

  function automatic int unsigned mask_idx(int unsigned sw_ch, int unsigned led_ch,
                                           int unsigned bt_ch);
    return sw_ch + led_ch + bt_ch + 2;
  endfunction

endpackage

// File: rtl/mmio_debounce.sv
// One-bit 2-flop synchroniser plus debounce counter and debounced level.
// rise pulses on the cycle the level flips from 0 to 1.
module mmio_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYC - 1);

  logic meta_q, sync_q, flip;
  logic [CntW-1:0] cnt_q;

  assign flip = (sync_q != level) && (cnt_q == CntMax);
  assign rise = flip && sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      cnt_q  <= '0;
      level  <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      if (sync_q == level || flip) cnt_q <= '0;
      else                         cnt_q <= cnt_q + 1'b1;
      if (flip) level <= sync_q;
    end
  end

endmodule

// File: rtl/mmio_ctrl.sv
// Registered, handshaked MMIO register window: switches, LEDs, debounced buttons,
// sticky button edges and SEPC. Define MMIO_IRQ_EN to add IRQ_MASK and the irq output.
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int unsigned SW_CH        = 3,
  parameter int unsigned LED_CH       = 2,
  parameter int unsigned BT_CH        = 5,
  parameter int unsigned DEBOUNCE_CYC = 20000,
  parameter logic [31:0] BASE_ADDR    = DefaultBaseAddr
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [3:0]          req_be,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  output logic                rsp_valid,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_err,
  input  logic [31:0]         sepc,
  input  logic [SW_CH*8-1:0]  switches,
  input  logic [BT_CH-1:0]    bt,
  output logic [LED_CH*8-1:0] led_out
`ifdef MMIO_IRQ_EN
  ,
  output logic                irq
`endif
);

  localparam int unsigned SwIdx   = sw_idx();
  localparam int unsigned LedIdx  = led_idx(SW_CH);
  localparam int unsigned BtIdx   = bt_idx(SW_CH, LED_CH);
  localparam int unsigned EdgeIdx = edge_idx(SW_CH, LED_CH, BT_CH);
  localparam int unsigned SepcIdx = sepc_idx(SW_CH, LED_CH, BT_CH);
`ifdef MMIO_IRQ_EN
  localparam int unsigned MaskIdx = mask_idx(SW_CH, LED_CH, BT_CH);
`endif

  state_e state_q;
  logic [SW_CH*8-1:0]  sw_meta_q, sw_sync_q;
  logic [LED_CH*8-1:0] led_q, led_d;
  logic [BT_CH-1:0]    edge_q, edge_clr, bt_level, bt_rise;
  logic [31:0]         idx, dec_rdata;
  logic                hit, accept, acc_wr, dec_err;
  logic                unused_bits;
`ifdef MMIO_IRQ_EN
  logic [BT_CH-1:0]    mask_q, mask_d;
`endif

  assign unused_bits = ^{req_be[3:1], req_wdata[31:8]};

  for (genvar g = 0; g < BT_CH; g++) begin : g_bt
    mmio_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (bt[g]),
      .level(bt_level[g]),
      .rise (bt_rise[g])
    );
  end

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid && req_ready;
  assign acc_wr    = accept && req_we;
  assign hit       = (req_addr[31:8] == BASE_ADDR[31:8]) && (req_addr[1:0] == 2'b00);
  assign idx       = {26'b0, req_addr[7:2]};
  assign led_out   = led_q;

  // Decode is shared by the response path and the write enables; writes only fire on accept.
  always_comb begin
    dec_rdata = '0;
    dec_err   = 1'b1;
    led_d     = led_q;
    edge_clr  = '0;
`ifdef MMIO_IRQ_EN
    mask_d    = mask_q;
`endif
    if (hit) begin
      for (int unsigned i = 0; i < SW_CH; i++) begin
        if (idx == SwIdx + i) begin
          dec_err   = 1'b0;
          dec_rdata = {24'b0, sw_sync_q[8*i +: 8]};
        end
      end
      for (int unsigned i = 0; i < LED_CH; i++) begin
        if (idx == LedIdx + i) begin
          dec_err   = 1'b0;
          dec_rdata = {24'b0, led_q[8*i +: 8]};
          if (acc_wr && req_be[0]) led_d[8*i +: 8] = req_wdata[7:0];
        end
      end
      for (int unsigned i = 0; i < BT_CH; i++) begin
        if (idx == BtIdx + i) begin
          dec_err   = 1'b0;
          dec_rdata = {31'b0, bt_level[i]};
        end
      end
      if (idx == EdgeIdx) begin
        dec_err   = 1'b0;
        dec_rdata = 32'(edge_q);
        if (acc_wr && req_be[0]) edge_clr = req_wdata[BT_CH-1:0];
      end
      if (idx == SepcIdx) begin
        dec_err   = 1'b0;
        dec_rdata = sepc;
      end
`ifdef MMIO_IRQ_EN
      if (idx == MaskIdx) begin
        dec_err   = 1'b0;
        dec_rdata = 32'(mask_q);
        if (acc_wr) mask_d = req_wdata[BT_CH-1:0];
      end
`endif
    end
    if (dec_err || req_we) dec_rdata = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            state_q   <= StResp;
            rsp_valid <= 1'b1;
            rsp_rdata <= dec_rdata;
            rsp_err   <= dec_err;
          end
        end
        default: begin
          state_q   <= StIdle;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Edge set wins over a simultaneous write-1-to-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      led_q     <= '0;
      edge_q    <= '0;
    end else begin
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
      led_q     <= led_d;
      edge_q    <= (edge_q & ~edge_clr) | bt_rise;
    end
  end

`ifdef MMIO_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      irq    <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq    <= |(edge_q & mask_q);
    end
  end
`endif

endmodule
